// File: rtl/multichannel_stream_bridge_pkg.sv
// Shared register map, bit positions and control bundle
// for the multichannel stream-to-bus bridge.
package multichannel_stream_bridge_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_THRESH = 3'd3;
  localparam logic [2:0] REG_FLAGS  = 3'd4;

  localparam int IRQ_EN_BIT = 8;
  localparam int FLUSH_BIT  = 9;

  localparam int ST_EMPTY_BIT = 16;
  localparam int ST_FULL_BIT  = 17;
  localparam int ST_OVF_BIT   = 18;
  localparam int ST_UDF_BIT   = 19;

  typedef struct packed {
    logic       irq_en;
    logic [2:0] ch_sel;
  } ctrl_t;

endpackage

// File: rtl/multichannel_stream_bridge_chan_fifo.sv
// Per-channel sample FIFO: memory, wrapping pointers and level.
// Callers gate push on !full and pop on !empty.
module chan_fifo #(
  parameter int DATA_SIZE = 28,
  parameter int DEPTH     = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_SIZE-1:0]     wdata,
  output logic [DATA_SIZE-1:0]     rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // flush outranks any push or pop on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LVL_MAX);
  assign empty = (level == '0);

endmodule

// File: rtl/multichannel_stream_bridge.sv
// Stream-to-bus bridge: per-channel FIFOs behind a small CPU
// register bank with threshold irq and sticky ovf/udf flags.
module multichannel_stream_bridge
  import multichannel_stream_bridge_pkg::*;
#(
  parameter int DATA_SIZE = 28,
  parameter int DEPTH     = 256,
  parameter int NUM_CH    = 2,
  localparam int CH_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 chipselect,
  input  logic [2:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  input  logic                 source_valid,
  input  logic [CH_WIDTH-1:0]  source_channel,
  input  logic [DATA_SIZE-1:0] source_data,
  output logic                 source_ready,
  output logic                 irq
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  ctrl_t                 ctrl;
  logic [ADDR_WIDTH:0]   thresh;
  logic [NUM_CH-1:0]     ovf, udf, ovf_set, udf_set;
  logic [NUM_CH-1:0]     ovf_clr, udf_clr;
  logic [NUM_CH-1:0]     push, pop, full, empty, hit;
  logic [DATA_SIZE-1:0]  rdata [NUM_CH];
  logic [ADDR_WIDTH:0]   level [NUM_CH];

  logic [DATA_SIZE-1:0]  sel_rdata;
  logic [ADDR_WIDTH:0]   sel_level;
  logic                  sel_full, sel_empty;
  logic                  sel_ovf, sel_udf;
  logic                  bus_rd, bus_wr, pop_req;
  logic                  flush, sel_ok;
  logic [31:0]           status, rd_next;
  logic                  wd_unused;

  assign bus_rd  = chipselect && read;
  assign bus_wr  = chipselect && write;
  assign sel_ok  = 32'(ctrl.ch_sel) < NUM_CH;
  assign pop_req = bus_rd && (address == REG_DATA);
  assign flush   = bus_wr && (address == REG_CTRL)
                   && write_data[FLUSH_BIT];
  assign wd_unused = ^write_data;

  // out-of-range tags or selects simply never match a channel
  always_comb begin
    source_ready = 1'b0;
    push      = '0;
    pop       = '0;
    ovf_set   = '0;
    udf_set   = '0;
    hit       = '0;
    sel_rdata = '0;
    sel_level = '0;
    sel_full  = 1'b0;
    sel_empty = 1'b0;
    sel_ovf   = 1'b0;
    sel_udf   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (source_channel == CH_WIDTH'(c)) begin
        source_ready = !full[c];
        push[c]      = source_valid && !full[c];
        ovf_set[c]   = source_valid && full[c];
      end
      if (ctrl.ch_sel == 3'(c)) begin
        sel_rdata  = rdata[c];
        sel_level  = level[c];
        sel_full   = full[c];
        sel_empty  = empty[c];
        sel_ovf    = ovf[c];
        sel_udf    = udf[c];
        pop[c]     = pop_req && !empty[c];
        udf_set[c] = pop_req && empty[c];
      end
      hit[c] = level[c] >= thresh;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    chan_fifo #(
      .DATA_SIZE(DATA_SIZE),
      .DEPTH    (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (push[g]),
      .pop    (pop[g]),
      .flush  (flush),
      .wdata  (source_data),
      .rdata  (rdata[g]),
      .level  (level[g]),
      .full   (full[g]),
      .empty  (empty[g])
    );
  end

  always_comb begin
    status = '0;
    status[ADDR_WIDTH:0] = sel_level;
    status[ST_EMPTY_BIT] = sel_empty;
    status[ST_FULL_BIT]  = sel_full;
    status[ST_OVF_BIT]   = sel_ovf;
    status[ST_UDF_BIT]   = sel_udf;
  end

  always_comb begin
    rd_next = '0;
    unique case (1'b1)
      address == REG_DATA:
        if (sel_ok && !sel_empty) rd_next = 32'(sel_rdata);
      address == REG_STATUS:
        if (sel_ok) rd_next = status;
      address == REG_CTRL: begin
        rd_next[2:0]        = ctrl.ch_sel;
        rd_next[IRQ_EN_BIT] = ctrl.irq_en;
      end
      address == REG_THRESH:
        rd_next = 32'(thresh);
      address == REG_FLAGS:
        rd_next = {16'b0, 8'(udf), 8'(ovf)};
      default: rd_next = '0;
    endcase
  end

  assign ovf_clr = (bus_wr && address == REG_FLAGS)
                   ? write_data[NUM_CH-1:0] : '0;
  assign udf_clr = (bus_wr && address == REG_FLAGS)
                   ? write_data[8 +: NUM_CH] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data <= '0;
      irq       <= 1'b0;
      ctrl      <= '0;
      thresh    <= (ADDR_WIDTH+1)'(DEPTH / 2);
      ovf       <= '0;
      udf       <= '0;
    end else begin
      if (bus_rd) read_data <= rd_next;
      irq <= ctrl.irq_en && (|hit);
      if (bus_wr && address == REG_CTRL) begin
        ctrl.ch_sel <= write_data[2:0];
        ctrl.irq_en <= write_data[IRQ_EN_BIT];
      end
      if (bus_wr && address == REG_THRESH)
        thresh <= write_data[ADDR_WIDTH:0];
      // a new event beats a concurrent clear
      ovf <= (ovf & ~ovf_clr) | ovf_set;
      udf <= (udf & ~udf_clr) | udf_set;
    end
  end

endmodule
